seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Listens on the multiplexed 7-segment bus (an/seg) at the receive end.
//  Demultiplexes the scanned digits into per-digit registers and decodes each glyph back to a 4-bit code.
//  Pulses once per complete scan frame.
//  Used as an on-chip loopback checker and as a bench monitor for the display path.
// PARAMETERS
//  STABLE_CYCLES  1        cycles an/seg must hold unchanged before a digit commits (1..255)
//  DIGIT_MASK     4'b0011  digits that must commit before frame_valid fires
//  STALE_CYCLES   1000000  cycles without a commit before that digit's stale bit sets
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  an           in   4   digit anodes, active-low
//  seg          in   7   segments, active-low, {a,b,c,d,e,f,g} = seg[6:0]
//  digit_code   out  16  decoded code per digit, digit i at [4i+3:4i]
//  digit_inval  out  4   per-digit: last committed pattern undecodable
//  digit_stale  out  4   per-digit: no commit for STALE_CYCLES
//  frame_valid  out  1   1-cycle pulse when every DIGIT_MASK digit has committed
//  bcast_mode   out  1   last stable an was 4'b0000 (all digits lit)
//  bcast_code   out  4   decoded code of the last stable broadcast pattern
// BEHAVIOUR
//  Reset: digit_code=16'hFFFF, bcast_code=4'hF, digit_inval=0, digit_stale=0, frame_valid=0, bcast_mode=0.
//    Stability and stale counters and the frame tracker clear to 0.
//  Sample stage: an/seg registered once. A stability counter increments while {an,seg} equals last cycle's value.
//    The counter reloads to 1 on any change and saturates at STABLE_CYCLES.
//  Commit: on the cycle the counter reaches STABLE_CYCLES, act on an:
//    an one-hot-low, index i -> digit_code[i], digit_inval[i] update; tracker[i] set; stale count i cleared; bcast_mode<=0.
//    an==4'b0000 -> bcast_code updates; bcast_mode<=1; no digit register or tracker change.
//    an==4'b1111 -> idle, nothing updates.
//    Any other an -> ignored.
//  Latency: bus change -> output update = STABLE_CYCLES+1 clk. Default: 2 clk.
//  Decode table (seg -> code):
//    0000001 -> 0;  1001111 -> 1;  0010010 -> 2;  0000110 -> 3;  1001100 -> 4
//    0100100 -> 5;  0100000 -> 6;  0001111 -> 7;  0000000 -> 8;  0000100 -> 9
//    1111111 -> F (blank, valid)
//    any other pattern -> code E, inval=1
//  Frame: when (tracker & DIGIT_MASK)==DIGIT_MASK at commit, frame_valid=1 the next cycle and tracker clears.
//    Commits are not held off; a commit in the clearing cycle sets its bit into the new frame.
//  Stale: per-digit counter saturates at STALE_CYCLES, then digit_stale[i]=1.
//    The next commit to digit i clears the counter and the bit in the same cycle.
//  rst mid-frame: all state returns to reset values; no frame_valid until a full new frame commits.
// CONFIGURATION
//  SEG_LETTER_DECODE_EN defined: extra table entries, each with inval=0:
//    1110001 -> A (L, low level);  0101011 -> B (mid-level glyph);  1001000 -> C (H, high level)
//  Undefined: those three patterns decode to E with inval=1.
// STRUCTURE
//  Package seg_pkg:
//    segment pattern localparams (SEG_0..SEG_9, SEG_BLANK, SEG_L, SEG_MID, SEG_H)
//    code localparams (CODE_BLANK=4'hF, CODE_INVALID=4'hE, CODE_L/MID/H=A/B/C)
//  One combinational sub-module, seg_glyph_decode: seg in -> {code, inval} out.
//    Shared by the digit and broadcast paths; it holds the SEG_LETTER_DECODE_EN ifdef.
// TESTING
//  1 Scan an=1110/seg=1001111, then an=1101/seg=0000001, each 1 clk; defaults.
//    -> digit_code[3:0]=1, [7:4]=0; frame_valid pulses once; inval=0.
//  2 Drive an=1110/seg=0100000 with STABLE_CYCLES=4, toggling seg every 3 clk.
//    -> no commit; once held 4 clk, digit 0 = 6 at cycle 5.
//  3 Drive an=0000/seg=1110001.
//    -> macro on: bcast_mode=1, bcast_code=A. Macro off: bcast_code=E.
//    -> digit_code unchanged in both cases.
//  4 Drive an=1110/seg=1111110.
//    -> digit_code[3:0]=E, digit_inval[0]=1.
//    -> a next valid seg=0010010 clears inval, code=2.
//  5 STALE_CYCLES=16; commit digit 0, then hold an=1111 for 20 clk.
//    -> digit_stale[0]=1 from cycle 17; the next commit clears it.
//  6 Commit digit 0 only, assert rst 1 clk, commit digit 1 only.
//    -> no frame_valid; after digit 0 commits again -> one frame_valid.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan decoder: segment patterns,
// decoded codes and anode idle/broadcast patterns.
package seg_pkg;

    // Active-low segment patterns, {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_L     = 7'b1110001;
    localparam logic [6:0] SEG_MID   = 7'b0101011;
    localparam logic [6:0] SEG_H     = 7'b1001000;

    localparam logic [3:0] CODE_BLANK   = 4'hF;
    localparam logic [3:0] CODE_INVALID = 4'hE;
    localparam logic [3:0] CODE_L       = 4'hA;
    localparam logic [3:0] CODE_MID     = 4'hB;
    localparam logic [3:0] CODE_H       = 4'hC;

    localparam logic [3:0] AN_IDLE  = 4'b1111;
    localparam logic [3:0] AN_BCAST = 4'b0000;

    typedef struct packed {
        logic [3:0] code;
        logic       inval;
    } glyph_t;

    function automatic glyph_t mk_glyph(input logic [3:0] code);
        mk_glyph = '{code: code, inval: 1'b0};
    endfunction

endpackage

// File: rtl/seg_scan_decoder_glyph.sv
// Combinational glyph decoder: active-low segment pattern -> {code, inval}.
// Letter glyphs L/mid/H decode only when SEG_LETTER_DECODE_EN is defined.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       inval
);

    glyph_t g;

    // Table lookup; anything not listed is an invalid glyph
    always_comb begin
        g = '{code: CODE_INVALID, inval: 1'b1};
        case (seg)
            SEG_0:     g = mk_glyph(4'd0);
            SEG_1:     g = mk_glyph(4'd1);
            SEG_2:     g = mk_glyph(4'd2);
            SEG_3:     g = mk_glyph(4'd3);
            SEG_4:     g = mk_glyph(4'd4);
            SEG_5:     g = mk_glyph(4'd5);
            SEG_6:     g = mk_glyph(4'd6);
            SEG_7:     g = mk_glyph(4'd7);
            SEG_8:     g = mk_glyph(4'd8);
            SEG_9:     g = mk_glyph(4'd9);
            SEG_BLANK: g = mk_glyph(CODE_BLANK);
`ifdef SEG_LETTER_DECODE_EN
            SEG_L:     g = mk_glyph(CODE_L);
            SEG_MID:   g = mk_glyph(CODE_MID);
            SEG_H:     g = mk_glyph(CODE_H);
`endif
            default:   g = '{code: CODE_INVALID, inval: 1'b1};
        endcase
    end

    assign code  = g.code;
    assign inval = g.inval;

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side 7-segment scan demultiplexer with per-digit decode, frame
// pulse and stale detection. Optional letter glyphs: SEG_LETTER_DECODE_EN.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int         STABLE_CYCLES = 1,
    parameter logic [3:0] DIGIT_MASK    = 4'b0011,
    parameter int         STALE_CYCLES  = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digit_code,
    output logic [3:0]  digit_inval,
    output logic [3:0]  digit_stale,
    output logic        frame_valid,
    output logic        bcast_mode,
    output logic [3:0]  bcast_code
);

    localparam int         SW  = $clog2(STALE_CYCLES + 1);
    localparam logic [7:0] STB = 8'(STABLE_CYCLES);
    localparam logic [SW-1:0] SMAX = SW'(STALE_CYCLES);

    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic [7:0]    stab;
    logic [7:0]    stab_nxt;
    logic          changed;
    logic          commit;
    logic [3:0]    dsel;
    logic [3:0]    trk;
    logic [3:0]    trk_nxt;
    logic          full;
    logic [3:0]    g_code;
    logic          g_inval;
    logic [SW-1:0] stale_cnt [4];

    seg_glyph_decode u_glyph (
        .seg   (seg_q),
        .code  (g_code),
        .inval (g_inval)
    );

    // Stability count for the incoming bus versus the held sample
    always_comb begin
        changed  = {an, seg} != {an_q, seg_q};
        stab_nxt = changed ? 8'd1 : ((stab >= STB) ? STB : stab + 8'd1);
    end

    // Sample stage; commit fires once, on the cycle stability is reached
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q   <= AN_IDLE;
            seg_q  <= SEG_BLANK;
            stab   <= 8'd0;
            commit <= 1'b0;
        end else begin
            an_q   <= an;
            seg_q  <= seg;
            stab   <= stab_nxt;
            commit <= (stab_nxt == STB) && (changed || stab != STB);
        end
    end

    // One-hot-low anode to digit select; other patterns select nothing
    always_comb begin
        dsel = 4'b0000;
        case (an_q)
            4'b1110: dsel = 4'b0001;
            4'b1101: dsel = 4'b0010;
            4'b1011: dsel = 4'b0100;
            4'b0111: dsel = 4'b1000;
            default: dsel = 4'b0000;
        endcase
        if (!commit) dsel = 4'b0000;
        trk_nxt = trk | dsel;
        full    = (trk_nxt & DIGIT_MASK) == DIGIT_MASK;
    end

    // Digit/broadcast registers and frame tracker
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_code  <= 16'hFFFF;
            digit_inval <= 4'b0000;
            bcast_mode  <= 1'b0;
            bcast_code  <= CODE_BLANK;
            trk         <= 4'b0000;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (dsel != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (dsel[i]) begin
                        digit_code[4*i +: 4] <= g_code;
                        digit_inval[i]       <= g_inval;
                    end
                end
                bcast_mode <= 1'b0;
                if (full) begin
                    frame_valid <= 1'b1;
                    trk         <= 4'b0000;
                end else begin
                    trk <= trk_nxt;
                end
            end else if (commit && an_q == AN_BCAST) begin
                bcast_code <= g_code;
                bcast_mode <= 1'b1;
            end
        end
    end

    // Per-digit staleness counters, cleared by a commit to that digit
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst || dsel[i]) begin
                stale_cnt[i] <= '0;
            end else if (stale_cnt[i] != SMAX) begin
                stale_cnt[i] <= stale_cnt[i] + 1'b1;
            end
        end
    end

    // Stale flag is the saturated counter
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            digit_stale[i] = (stale_cnt[i] == SMAX);
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed scoreboard bench for seg_scan_decoder: main instance with a
// short stale window, second instance with STABLE_CYCLES=4.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an4 = 4'hF;
    logic [6:0]  seg4 = 7'h7F;

    logic [15:0] digit_code, digit_code4;
    logic [3:0]  digit_inval, digit_inval4;
    logic [3:0]  digit_stale, digit_stale4;
    logic        frame_valid, frame_valid4;
    logic        bcast_mode, bcast_mode4;
    logic [3:0]  bcast_code, bcast_code4;

    seg_scan_decoder #(
        .STALE_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .an          (an),
        .seg         (seg),
        .digit_code  (digit_code),
        .digit_inval (digit_inval),
        .digit_stale (digit_stale),
        .frame_valid (frame_valid),
        .bcast_mode  (bcast_mode),
        .bcast_code  (bcast_code)
    );

    seg_scan_decoder #(
        .STABLE_CYCLES (4)
    ) dut4 (
        .clk         (clk),
        .rst         (rst),
        .an          (an4),
        .seg         (seg4),
        .digit_code  (digit_code4),
        .digit_inval (digit_inval4),
        .digit_stale (digit_stale4),
        .frame_valid (frame_valid4),
        .bcast_mode  (bcast_mode4),
        .bcast_code  (bcast_code4)
    );

    always #5 clk = ~clk;

    int fcnt = 0;
    always @(posedge clk) begin
        if (frame_valid) fcnt <= fcnt + 1;
    end

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s);
        an  = a;
        seg = s;
    endtask

    task automatic drive4(input logic [3:0] a, input logic [6:0] s);
        an4  = a;
        seg4 = s;
    endtask

    task automatic push(input string tag, input logic [15:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [15:0] obs);
        sb_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        push(tag, exp);
        pop_check(obs);
    endtask

    logic [3:0] exp_letter;
    int f0;

    initial begin
`ifdef SEG_LETTER_DECODE_EN
        exp_letter = 4'hA;
`else
        exp_letter = 4'hE;
`endif
        rst = 1'b1;
        tick(2);
        chk("rst_code", digit_code, 16'hFFFF);
        chk("rst_inval", 16'(digit_inval), 16'h0);
        chk("rst_stale", 16'(digit_stale), 16'h0);
        chk("rst_fv", 16'(frame_valid), 16'h0);
        chk("rst_bmode", 16'(bcast_mode), 16'h0);
        chk("rst_bcode", 16'(bcast_code), 16'hF);
        rst = 1'b0;
        tick(2);

        // two-digit scan, one clk each
        f0 = fcnt;
        drive(4'b1110, 7'b1001111);
        tick;
        drive(4'b1101, 7'b0000001);
        tick;
        chk("t1_d0", 16'(digit_code[3:0]), 16'h1);
        drive(4'b1111, 7'b1111111);
        tick;
        chk("t1_code", digit_code, 16'hFF01);
        chk("t1_fv", 16'(frame_valid), 16'h1);
        chk("t1_inval", 16'(digit_inval), 16'h0);
        tick;
        chk("t1_fv_off", 16'(frame_valid), 16'h0);
        tick(3);
        chk("t1_fcnt", 16'(fcnt - f0), 16'h1);

        // broadcast of the L glyph
        drive(4'b0000, 7'b1110001);
        tick(2);
        chk("t3_bmode", 16'(bcast_mode), 16'h1);
        chk("t3_bcode", 16'(bcast_code), 16'(exp_letter));
        chk("t3_code", digit_code, 16'hFF01);
        drive(4'b1111, 7'b1111111);
        tick;

        // invalid glyph, then valid one clears inval
        drive(4'b1110, 7'b1111110);
        tick;
        drive(4'b1111, 7'b1111111);
        tick;
        chk("t4_code", digit_code, 16'hFF0E);
        chk("t4_inval", 16'(digit_inval), 16'h1);
        chk("t4_bmode", 16'(bcast_mode), 16'h0);
        drive(4'b1110, 7'b0010010);
        tick;
        drive(4'b1111, 7'b1111111);
        tick;
        chk("t4_code2", digit_code, 16'hFF02);
        chk("t4_inval2", 16'(digit_inval), 16'h0);

        // STABLE_CYCLES=4 with seg toggling every 3 clk
        for (int k = 0; k < 4; k++) begin
            drive4(4'b1110, (k % 2 == 0) ? 7'b0100000 : 7'b0000000);
            tick(3);
        end
        chk("t2_toggle", 16'(digit_code4[3:0]), 16'hF);
        drive4(4'b1110, 7'b0100000);
        tick(4);
        chk("t2_c4", 16'(digit_code4[3:0]), 16'hF);
        tick;
        chk("t2_c5", 16'(digit_code4[3:0]), 16'h6);
        drive4(4'b1111, 7'b1111111);

        // stale after 16 idle cycles
        rst = 1'b1;
        tick;
        rst = 1'b0;
        drive(4'b1110, 7'b0001111);
        tick;
        drive(4'b1111, 7'b1111111);
        tick;
        chk("t5_code", 16'(digit_code[3:0]), 16'h7);
        chk("t5_st0", 16'(digit_stale[0]), 16'h0);
        tick(15);
        chk("t5_st15", 16'(digit_stale[0]), 16'h0);
        tick;
        chk("t5_st16", 16'(digit_stale[0]), 16'h1);
        drive(4'b1110, 7'b0000110);
        tick;
        drive(4'b1111, 7'b1111111);
        tick;
        chk("t5_clr", 16'(digit_stale[0]), 16'h0);
        chk("t5_code2", 16'(digit_code[3:0]), 16'h3);

        // reset mid-frame discards the partial frame
        rst = 1'b1;
        tick;
        rst = 1'b0;
        drive(4'b1110, 7'b0100100);
        tick;
        drive(4'b1111, 7'b1111111);
        tick;
        chk("t6_d0", digit_code, 16'hFFF5);
        f0 = fcnt;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t6_rst", digit_code, 16'hFFFF);
        drive(4'b1101, 7'b0000100);
        tick;
        drive(4'b1111, 7'b1111111);
        tick;
        chk("t6_d1", digit_code, 16'hFF9F);
        tick(2);
        chk("t6_nofv", 16'(fcnt - f0), 16'h0);
        drive(4'b1110, 7'b1001100);
        tick;
        drive(4'b1111, 7'b1111111);
        tick;
        chk("t6_fv", 16'(frame_valid), 16'h1);
        chk("t6_code", digit_code, 16'hFF94);
        tick(2);
        chk("t6_fcnt", 16'(fcnt - f0), 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
